// File: rtl/udp_frame_gen.sv
// udp_frame_gen: UDP test-frame source (header beat + 64-bit payload stream) with inter-frame gap.
// Optional macro UDP_GEN_ERR_INJECT_EN adds err_inject, flagging tuser on every frame's last beat.
module udp_frame_gen #(
  parameter logic [31:0] SRC_IP     = 32'hC0A80102,
  parameter logic [31:0] DST_IP     = 32'hC0A80101,
  parameter logic [15:0] SRC_PORT   = 16'd1234,
  parameter logic [15:0] DST_PORT   = 16'd5678,
  parameter int          GAP_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef UDP_GEN_ERR_INJECT_EN
  input  logic         err_inject,
`endif
  input  logic         start,
  input  logic [15:0]  frame_count,
  input  logic [15:0]  payload_len,
  output logic         m_udp_hdr_valid,
  input  logic         m_udp_hdr_ready,
  output logic [111:0] m_udp_hdr_data,
  output logic [63:0]  m_udp_payload_axis_tdata,
  output logic [7:0]   m_udp_payload_axis_tkeep,
  output logic         m_udp_payload_axis_tvalid,
  input  logic         m_udp_payload_axis_tready,
  output logic         m_udp_payload_axis_tlast,
  output logic         m_udp_payload_axis_tuser,
  output logic         busy,
  output logic         done,
  output logic [15:0]  frames_sent
);
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, GAP} state_t;
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  state_t      r_state;
  logic [15:0] r_len, r_fcount, r_sent, r_gap;
  logic [12:0] r_beat;
  logic [7:0]  r_fidx;
  logic        r_busy, r_done;
  logic [15:0] w_len, w_len_m1;
  logic [63:0] w_data;
  logic [7:0]  w_keep;
  logic        w_last, w_hvalid, w_tvalid;
`ifdef UDP_GEN_ERR_INJECT_EN
  logic        r_err;
`endif
  assign w_len    = payload_len > 16'd65527 ? 16'd65527 : payload_len;
  assign w_len_m1 = r_len - 16'd1;
  assign w_last   = r_beat == w_len_m1[15:3];
  assign w_hvalid = r_state == HDR;
  assign w_tvalid = r_state == PAYLOAD;
  assign w_keep   = !w_last || r_len[2:0] == 3'd0 ? 8'hFF : (8'd1 << r_len[2:0]) - 8'd1;
  // Lane i carries (8*beat + i + frame index) mod 256; only beat[4:0] matters modulo 256.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < 8; i++) w_data[8*i +: 8] = {r_beat[4:0], 3'b000} + 8'(i) + r_fidx;
  end
  assign m_udp_hdr_valid           = w_hvalid;
  assign m_udp_hdr_data            = w_hvalid ? {SRC_IP, DST_IP, SRC_PORT, DST_PORT, r_len + 16'd8} : '0;
  assign m_udp_payload_axis_tvalid = w_tvalid;
  assign m_udp_payload_axis_tdata  = w_tvalid ? w_data : '0;
  assign m_udp_payload_axis_tkeep  = w_tvalid ? w_keep : '0;
  assign m_udp_payload_axis_tlast  = w_tvalid && w_last;
`ifdef UDP_GEN_ERR_INJECT_EN
  assign m_udp_payload_axis_tuser  = w_tvalid && w_last && r_err;
`else
  assign m_udp_payload_axis_tuser  = 1'b0;
`endif
  assign busy        = r_busy;
  assign done        = r_done;
  assign frames_sent = r_sent;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_fcount <= '0;
      r_sent   <= '0;
      r_gap    <= '0;
      r_beat   <= '0;
      r_fidx   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef UDP_GEN_ERR_INJECT_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_sent <= '0;
          if (frame_count != 16'd0 && payload_len != 16'd0) begin
            r_len    <= w_len;
            r_fcount <= frame_count;
            r_fidx   <= '0;
            r_beat   <= '0;
            r_busy   <= 1'b1;
            r_state  <= HDR;
`ifdef UDP_GEN_ERR_INJECT_EN
            r_err    <= err_inject;
`endif
          end else r_done <= 1'b1;
        end
        HDR: if (m_udp_hdr_ready) r_state <= PAYLOAD;
        PAYLOAD: if (m_udp_payload_axis_tready) begin
          if (w_last) begin
            r_beat <= '0;
            r_fidx <= r_fidx + 8'd1;
            r_sent <= r_sent + {15'd0, r_sent != 16'hFFFF};
            r_gap  <= '0;
            if (r_sent + 16'd1 == r_fcount) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else r_state <= GAP_CYCLES > 0 ? GAP : HDR;
          end else r_beat <= r_beat + 13'd1;
        end
        GAP: begin
          r_gap <= r_gap + 16'd1;
          if (r_gap == GAP_LAST) r_state <= HDR;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
